oven_controller: RTL and testbench

OVEN_CONTROLLER -- requirements
Module: oven_controller

---
 rtl/oven_pkg.sv | 35 +++
 rtl/oven_if.sv | 32 +++
 rtl/oven_tick_gen.sv | 30 +++
 rtl/oven_controller.sv | 105 ++++++++++
 tb/tb_oven_controller.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/oven_pkg.sv
// rtl/oven_pkg.sv - oven controller states, seven-segment glyphs and display helper
package oven_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COOK  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Active-high segments, bit0 = a ... bit6 = g
  localparam logic [6:0] SEG_I = 7'h30;  // e f
  localparam logic [6:0] SEG_D = 7'h5E;  // b c d e g
  localparam logic [6:0] SEG_L = 7'h38;  // d e f
  localparam logic [6:0] SEG_E = 7'h79;  // a d e f g
  localparam logic [6:0] SEG_P = 7'h73;  // a b e f g
  localparam logic [6:0] SEG_R = 7'h50;  // e g
  localparam logic [6:0] SEG_O = 7'h3F;  // a b c d e f
  localparam logic [6:0] SEG_C = 7'h39;  // a d e f
  localparam logic [6:0] SEG_A = 7'h77;  // a b c e f g
  localparam logic [6:0] SEG_U = 7'h3E;  // b c d e f
  localparam logic [6:0] SEG_S = 7'h6D;  // a c d f g
  localparam logic [6:0] SEG_N = 7'h54;  // c e g

  // Four display characters, leftmost in the top bits
  function automatic logic [27:0] state_chars(input state_t s);
    case (s)
      ST_COOK:  state_chars = {SEG_P, SEG_R, SEG_O, SEG_C};
      ST_PAUSE: state_chars = {SEG_P, SEG_A, SEG_U, SEG_S};
      ST_DONE:  state_chars = {SEG_D, SEG_O, SEG_N, SEG_E};
      default:  state_chars = {SEG_I, SEG_D, SEG_L, SEG_E};
    endcase
  endfunction

endpackage

// File: rtl/oven_if.sv
// rtl/oven_if.sv - oven controller front-panel bus
interface oven_if #(
  parameter int TIMER_W      = 7,
  parameter int POWER_LEVELS = 2
);
  localparam int PWR_W = $clog2(POWER_LEVELS);

  logic [PWR_W-1:0]   power;
  logic [TIMER_W-1:0] timer;
  logic               door_status;
  logic               start_button;
  logic               cancel_button;
  logic [6:0]         state_display1;
  logic [6:0]         state_display2;
  logic [6:0]         state_display3;
  logic [6:0]         state_display4;
  logic [TIMER_W-1:0] time_display;
  logic               magnetron_en;
  logic               done_pulse;

  modport master (
    output power, timer, door_status, start_button, cancel_button,
    input  state_display1, state_display2, state_display3, state_display4,
    input  time_display, magnetron_en, done_pulse
  );

  modport slave (
    input  power, timer, door_status, start_button, cancel_button,
    output state_display1, state_display2, state_display3, state_display4,
    output time_display, magnetron_en, done_pulse
  );
endinterface

// File: rtl/oven_tick_gen.sv
// rtl/oven_tick_gen.sv - seconds prescaler with enable, clear and hold
module oven_tick_gen #(
  parameter int TICKS_PER_SEC = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_enable,
  input  logic i_clear,
  input  logic i_hold,
  output logic o_tick
);
  localparam int CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_SEC - 1);

  logic [CNT_W-1:0] r_cnt;

  // Tick on the last count of a second, suppressed while held (door open / cancel)
  assign o_tick = i_enable && !i_hold && !i_clear && (r_cnt == LAST);

  // Prescaler counts only while enabled and not held; wraps on the tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && !i_hold) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/oven_controller.sv
// rtl/oven_controller.sv - microwave oven controller top
module oven_controller
  import oven_pkg::*;
#(
  parameter int TIMER_W       = 7,
  parameter int TICKS_PER_SEC = 1,
  parameter int POWER_LEVELS  = 2
) (
  input  logic  clk,
  input  logic  rst_n,
  oven_if.slave bus
);
  localparam int PWR_W = $clog2(POWER_LEVELS);
  localparam logic [PWR_W-1:0] MAX_LVL = PWR_W'(POWER_LEVELS - 1);

  state_t             r_state;
  logic [TIMER_W-1:0] r_remaining;
  logic [PWR_W-1:0]   r_level;
  logic [PWR_W-1:0]   r_pwm_cnt;
  logic               r_done_pulse;
  logic               w_tick;
  logic [PWR_W-1:0]   w_level_in;
  logic               w_stay_cook;

  assign w_level_in  = (bus.power > MAX_LVL) ? MAX_LVL : bus.power;
  assign w_stay_cook = bus.door_status && !bus.cancel_button;

  oven_tick_gen #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_enable (r_state == ST_COOK),
    .i_clear  ((r_state == ST_IDLE) || (r_state == ST_DONE)),
    .i_hold   (!w_stay_cook),
    .o_tick   (w_tick)
  );

  // Main state machine: countdown, power latch, PWM phase and completion strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_remaining  <= '0;
      r_level      <= '0;
      r_pwm_cnt    <= '0;
      r_done_pulse <= 1'b0;
    end else begin
      r_done_pulse <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start_button && bus.door_status && (bus.timer != '0) &&
              !bus.cancel_button) begin
            r_state     <= ST_COOK;
            r_remaining <= bus.timer;
            r_level     <= w_level_in;
            r_pwm_cnt   <= '0;
          end
        end
        ST_COOK: begin
          if (bus.cancel_button) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
          end else if (!bus.door_status) begin
            r_state <= ST_PAUSE;
          end else begin
            r_pwm_cnt <= (r_pwm_cnt == MAX_LVL) ? '0 : r_pwm_cnt + 1'b1;
            if (w_tick) begin
              r_remaining <= r_remaining - 1'b1;
              if (r_remaining == TIMER_W'(1)) begin
                r_state      <= ST_DONE;
                r_done_pulse <= 1'b1;
              end
            end
          end
        end
        ST_PAUSE: begin
          if (bus.cancel_button) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
          end else if (bus.start_button && bus.door_status) begin
            r_state <= ST_COOK;
          end
        end
        default: begin
          if (!bus.door_status) begin
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // Outputs decode registered state; only the idle time preview follows the input
  always_comb begin
    bus.time_display = '0;
    case (r_state)
      ST_IDLE:           bus.time_display = bus.timer;
      ST_COOK, ST_PAUSE: bus.time_display = r_remaining;
      default:           bus.time_display = '0;
    endcase
  end

  assign {bus.state_display1, bus.state_display2,
          bus.state_display3, bus.state_display4} = state_chars(r_state);
  assign bus.magnetron_en = (r_state == ST_COOK) && (r_pwm_cnt <= r_level);
  assign bus.done_pulse   = r_done_pulse;
endmodule

// File: tb/tb_oven_controller.sv
// tb/tb_oven_controller.sv - directed self-checking bench for oven_controller
module tb_oven_controller;
  logic [27:0] exp_idle, exp_cook, exp_paus, exp_done;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst3_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  oven_if #(.TIMER_W(7), .POWER_LEVELS(2)) bus ();
  oven_if #(.TIMER_W(7), .POWER_LEVELS(2)) bus3 ();

  oven_controller #(.TIMER_W(7), .TICKS_PER_SEC(1), .POWER_LEVELS(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  oven_controller #(.TIMER_W(7), .TICKS_PER_SEC(3), .POWER_LEVELS(2)) dut3 (
    .clk(clk), .rst_n(rst3_n), .bus(bus3)
  );

  logic [27:0] disp, disp3;
  assign disp  = {bus.state_display1, bus.state_display2, bus.state_display3, bus.state_display4};
  assign disp3 = {bus3.state_display1, bus3.state_display2, bus3.state_display3, bus3.state_display4};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic to_idle();
    bus.door_status = 1'b0;
    tick();
    bus.door_status = 1'b1;
    check("back_to_idle", {4'h0, disp}, {4'h0, exp_idle});
  endtask

  initial begin
    // Glyph strings: I d L E / P r O C / P A U S / d O n E
    exp_idle = {7'h30, 7'h5E, 7'h38, 7'h79};
    exp_cook = {7'h73, 7'h50, 7'h3F, 7'h39};
    exp_paus = {7'h73, 7'h77, 7'h3E, 7'h6D};
    exp_done = {7'h5E, 7'h3F, 7'h54, 7'h79};

    bus.power = 1'b1;  bus.timer = 7'd100; bus.door_status = 1'b1;
    bus.start_button = 1'b0; bus.cancel_button = 1'b0;
    bus3.power = 1'b1; bus3.timer = 7'd2;  bus3.door_status = 1'b1;
    bus3.start_button = 1'b0; bus3.cancel_button = 1'b0;

    // Reset state
    #1;
    check("rst_disp", {4'h0, disp}, {4'h0, exp_idle});
    check("rst_mag", 32'(bus.magnetron_en), 32'd0);
    check("rst_done", 32'(bus.done_pulse), 32'd0);
    check("rst_time", 32'(bus.time_display), 32'd100);
    tick(); tick();
    rst_n = 1'b1; rst3_n = 1'b1;
    tick();
    check("idle_hold", {4'h0, disp}, {4'h0, exp_idle});

    // Full power, 100 s
    bus.start_button = 1'b1; tick(); bus.start_button = 1'b0;
    for (int i = 0; i < 100; i++) begin
      check("full_disp", {4'h0, disp}, {4'h0, exp_cook});
      check("full_mag", 32'(bus.magnetron_en), 32'd1);
      check("full_time", 32'(bus.time_display), 32'(100 - i));
      tick();
    end
    check("full_done_disp", {4'h0, disp}, {4'h0, exp_done});
    check("full_done_pulse", 32'(bus.done_pulse), 32'd1);
    check("full_done_time", 32'(bus.time_display), 32'd0);
    check("full_done_mag", 32'(bus.magnetron_en), 32'd0);
    bus.start_button = 1'b1; bus.cancel_button = 1'b1; tick();
    bus.start_button = 1'b0; bus.cancel_button = 1'b0;
    check("done_pulse_once", 32'(bus.done_pulse), 32'd0);
    check("done_ignores_btn", {4'h0, disp}, {4'h0, exp_done});
    to_idle();

    // Half power, 4 s: magnetron 1,0,1,0
    bus.timer = 7'd4; bus.power = 1'b0;
    bus.start_button = 1'b1; tick(); bus.start_button = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("half_mag", 32'(bus.magnetron_en), (i % 2 == 0) ? 32'd1 : 32'd0);
      check("half_time", 32'(bus.time_display), 32'(4 - i));
      tick();
    end
    check("half_done", {4'h0, disp}, {4'h0, exp_done});
    check("half_pulse", 32'(bus.done_pulse), 32'd1);
    to_idle();

    // Pause / resume, 10 s
    bus.timer = 7'd10; bus.power = 1'b1;
    bus.start_button = 1'b1; tick(); bus.start_button = 1'b0;
    tick(); tick(); tick();
    check("pre_pause_time", 32'(bus.time_display), 32'd7);
    bus.door_status = 1'b0; tick();
    check("pause_disp", {4'h0, disp}, {4'h0, exp_paus});
    check("pause_time", 32'(bus.time_display), 32'd7);
    check("pause_mag", 32'(bus.magnetron_en), 32'd0);
    for (int i = 0; i < 4; i++) tick();
    check("pause_hold_disp", {4'h0, disp}, {4'h0, exp_paus});
    check("pause_hold_time", 32'(bus.time_display), 32'd7);
    bus.door_status = 1'b1; bus.start_button = 1'b1; tick(); bus.start_button = 1'b0;
    check("resume_disp", {4'h0, disp}, {4'h0, exp_cook});
    check("resume_time", 32'(bus.time_display), 32'd7);
    for (int i = 1; i <= 6; i++) begin
      tick();
      check("resume_time_n", 32'(bus.time_display), 32'(7 - i));
    end
    check("resume_still_cook", {4'h0, disp}, {4'h0, exp_cook});
    tick();
    check("resume_done", {4'h0, disp}, {4'h0, exp_done});
    check("resume_pulse", 32'(bus.done_pulse), 32'd1);
    to_idle();

    // Rejected starts
    bus.timer = 7'd5; bus.door_status = 1'b0; bus.start_button = 1'b1; tick();
    check("rej_door_open", {4'h0, disp}, {4'h0, exp_idle});
    bus.door_status = 1'b1; bus.timer = 7'd0; tick();
    check("rej_timer0", {4'h0, disp}, {4'h0, exp_idle});
    bus.timer = 7'd5; bus.cancel_button = 1'b1; tick();
    check("rej_cancel", {4'h0, disp}, {4'h0, exp_idle});
    bus.cancel_button = 1'b0; tick(); bus.start_button = 1'b0;
    check("cook5", {4'h0, disp}, {4'h0, exp_cook});
    tick();
    check("cook5_time", 32'(bus.time_display), 32'd4);
    bus.cancel_button = 1'b1; bus.start_button = 1'b1; tick();
    bus.cancel_button = 1'b0; bus.start_button = 1'b0;
    check("cancel_disp", {4'h0, disp}, {4'h0, exp_idle});
    check("cancel_mag", 32'(bus.magnetron_en), 32'd0);
    check("cancel_time", 32'(bus.time_display), 32'd5);

    // Asynchronous reset mid-cook
    bus.timer = 7'd10;
    bus.start_button = 1'b1; tick(); bus.start_button = 1'b0;
    tick();
    check("pre_rst_mag", 32'(bus.magnetron_en), 32'd1);
    rst_n = 1'b0; #2;
    check("async_rst_mag", 32'(bus.magnetron_en), 32'd0);
    check("async_rst_disp", {4'h0, disp}, {4'h0, exp_idle});
    tick(); rst_n = 1'b1; tick();
    bus.start_button = 1'b1; tick(); bus.start_button = 1'b0;
    check("post_rst_cook", {4'h0, disp}, {4'h0, exp_cook});
    check("post_rst_time", 32'(bus.time_display), 32'd10);

    // Three ticks per second, 2 s -> DONE six cycles after start
    bus3.start_button = 1'b1; tick(); bus3.start_button = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      check("tps3_cook", {4'h0, disp3}, {4'h0, exp_cook});
      check("tps3_time", 32'(bus3.time_display), (i <= 3) ? 32'd2 : 32'd1);
      tick();
    end
    check("tps3_cook5", {4'h0, disp3}, {4'h0, exp_cook});
    tick();
    check("tps3_done", {4'h0, disp3}, {4'h0, exp_done});
    check("tps3_pulse", 32'(bus3.done_pulse), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
